// File: rtl/rsa_avm_uart_wrapper.sv
// Avalon-MM master that streams RSA key N, key D and ciphertext bytes from a UART,
// runs an external mod-exp core, and writes the plaintext back out through the UART.
module rsa_avm_uart_wrapper #(
    parameter int W           = 256,
    parameter int RX_ADDR     = 0,
    parameter int TX_ADDR     = 4,
    parameter int STATUS_ADDR = 8,
    parameter int RX_OK_BIT   = 7,
    parameter int TX_OK_BIT   = 6,
    parameter int CNT_W       = 16
) (
    input  logic             avm_clk,
    input  logic             avm_rst,
    output logic [4:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    input  logic             avm_waitrequest,
    output logic             core_start,
    output logic [W-1:0]     core_a,
    output logic [W-1:0]     core_d,
    output logic [W-1:0]     core_n,
    input  logic [W-1:0]     core_result,
    input  logic             core_finished,
    input  logic             i_rekey,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_blocks_done
);
    localparam int NB   = W / 8;
    localparam int BC_W = $clog2(NB + 1);
    localparam logic [BC_W-1:0] RX_LAST = BC_W'(NB - 1);
    localparam logic [BC_W-1:0] TX_LAST = BC_W'(NB - 2);

    localparam logic [2:0] S_KEY_N = 3'd0;
    localparam logic [2:0] S_KEY_D = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;

    localparam logic PH_POLL = 1'b0;
    localparam logic PH_XFER = 1'b1;

    logic [2:0]       state_reg;
    logic             phase_reg;
    logic [BC_W-1:0]  byte_cnt_reg;
    logic [W-1:0]     n_reg, d_reg, a_reg;
    // Only the low W-8 result bits are ever transmitted, so only those are kept.
    logic [W-9:0]     res_reg;
    logic             calc_first_reg;
    logic             rekey_pending_reg;
    logic [CNT_W-1:0] blocks_done_reg;

    logic access_done;
    logic unused_bits;

    assign access_done = (avm_read | avm_write) & ~avm_waitrequest;
    assign unused_bits = ^{avm_readdata[31:8], core_result[W-1:W-8]};

    assign core_a        = a_reg;
    assign core_d        = d_reg;
    assign core_n        = n_reg;
    assign core_start    = (state_reg == S_CALC) & calc_first_reg;
    assign o_blocks_done = blocks_done_reg;
    assign o_busy        = !((state_reg == S_DATA) && (phase_reg == PH_POLL) && (byte_cnt_reg == '0));

    // Bus outputs decode purely from registered state, so they hold during waitrequest.
    always_comb begin
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = 5'(STATUS_ADDR);
        avm_writedata = 32'd0;
        if (state_reg != S_CALC) begin
            if (phase_reg == PH_POLL) begin
                avm_read = 1'b1;
            end else if (state_reg == S_SEND) begin
                avm_write     = 1'b1;
                avm_address   = 5'(TX_ADDR);
                avm_writedata = {24'd0, res_reg[W-9 -: 8]};
            end else begin
                avm_read    = 1'b1;
                avm_address = 5'(RX_ADDR);
            end
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_reg         <= S_KEY_N;
            phase_reg         <= PH_POLL;
            byte_cnt_reg      <= '0;
            n_reg             <= '0;
            d_reg             <= '0;
            a_reg             <= '0;
            res_reg           <= '0;
            calc_first_reg    <= 1'b0;
            rekey_pending_reg <= 1'b0;
            blocks_done_reg   <= '0;
        end else begin
            if (i_rekey) begin
                rekey_pending_reg <= 1'b1;
            end
            case (state_reg)
                S_KEY_N, S_KEY_D, S_DATA: begin
                    if (access_done) begin
                        if (phase_reg == PH_POLL) begin
                            if (avm_readdata[RX_OK_BIT]) begin
                                phase_reg <= PH_XFER;
                            end
                        end else begin
                            phase_reg <= PH_POLL;
                            if (state_reg == S_KEY_N) n_reg <= {n_reg[W-9:0], avm_readdata[7:0]};
                            if (state_reg == S_KEY_D) d_reg <= {d_reg[W-9:0], avm_readdata[7:0]};
                            if (state_reg == S_DATA)  a_reg <= {a_reg[W-9:0], avm_readdata[7:0]};
                            if (byte_cnt_reg == RX_LAST) begin
                                byte_cnt_reg <= '0;
                                case (state_reg)
                                    S_KEY_N: state_reg <= S_KEY_D;
                                    S_KEY_D: state_reg <= S_DATA;
                                    default: begin
                                        state_reg      <= S_CALC;
                                        calc_first_reg <= 1'b1;
                                    end
                                endcase
                            end else begin
                                byte_cnt_reg <= byte_cnt_reg + BC_W'(1);
                            end
                        end
                    end
                end
                S_CALC: begin
                    // A finished pulse coincident with start belongs to a previous run; ignore it.
                    calc_first_reg <= 1'b0;
                    if (!calc_first_reg && core_finished) begin
                        res_reg   <= core_result[W-9:0];
                        state_reg <= S_SEND;
                        phase_reg <= PH_POLL;
                    end
                end
                S_SEND: begin
                    if (access_done) begin
                        if (phase_reg == PH_POLL) begin
                            if (avm_readdata[TX_OK_BIT]) begin
                                phase_reg <= PH_XFER;
                            end
                        end else begin
                            phase_reg <= PH_POLL;
                            res_reg   <= res_reg << 8;
                            if (byte_cnt_reg == TX_LAST) begin
                                byte_cnt_reg    <= '0;
                                blocks_done_reg <= blocks_done_reg + CNT_W'(1);
                                if (rekey_pending_reg || i_rekey) begin
                                    rekey_pending_reg <= 1'b0;
                                    state_reg         <= S_KEY_N;
                                end else begin
                                    state_reg <= S_DATA;
                                end
                            end else begin
                                byte_cnt_reg <= byte_cnt_reg + BC_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= S_KEY_N;
                    phase_reg <= PH_POLL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_avm_uart_wrapper.sv
// Scoreboard bench: behavioural UART slave and RSA core around a W=32 wrapper;
// expected TX bytes and core operands are queued by stimulus and checked by monitors.
module tb_rsa_avm_uart_wrapper;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest;
    logic          core_start;
    logic [W-1:0]  core_a, core_d, core_n;
    logic [W-1:0]  core_result;
    logic          core_finished;
    logic          i_rekey;
    logic          o_busy;
    logic [15:0]   o_blocks_done;

    always #5 clk = ~clk;

    rsa_avm_uart_wrapper #(.W(W)) dut (
        .avm_clk(clk), .avm_rst(rst),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .core_start(core_start), .core_a(core_a), .core_d(core_d), .core_n(core_n),
        .core_result(core_result), .core_finished(core_finished),
        .i_rekey(i_rekey), .o_busy(o_busy), .o_blocks_done(o_blocks_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  rx_q[$];
    logic [31:0] exp_tx_q[$];
    logic [31:0] obs_tx_q[$];
    logic [95:0] exp_core_q[$];
    int wait_cycles = 0;
    bit rx_gate = 1'b1;
    bit early_fin = 1'b0;
    int status_reads = 0;
    int bad_rx = 0;
    int bad_acc = 0;
    int tx_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] a, input logic [31:0] d, input logic [31:0] n);
        logic [63:0] r;
        logic [63:0] b;
        r = 64'd1;
        b = {32'd0, a % n};
        for (int i = 0; i < 32; i++) begin
            if (d[i]) r = (r * b) % {32'd0, n};
            b = (b * b) % {32'd0, n};
        end
        return r[31:0];
    endfunction

    // UART slave: decides waitrequest for the coming edge and performs side effects on completion.
    initial begin
        int wcnt;
        wcnt = 0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                avm_waitrequest = 1'b0;
                wcnt = 0;
            end else if (avm_read || avm_write) begin
                if (wcnt < wait_cycles) begin
                    avm_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    wcnt = 0;
                    if (avm_read && avm_address == 5'd8) begin
                        status_reads++;
                        avm_readdata = {24'd0, (rx_gate && rx_q.size() > 0), 1'b1, 6'd0};
                    end else if (avm_read && avm_address == 5'd0) begin
                        if (!rx_gate || rx_q.size() == 0) begin
                            bad_rx++;
                            avm_readdata = 32'd0;
                        end else begin
                            avm_readdata = {24'd0, rx_q.pop_front()};
                        end
                    end else if (avm_write && avm_address == 5'd4) begin
                        obs_tx_q.push_back(avm_writedata);
                        tx_total++;
                    end else begin
                        bad_acc++;
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    // RSA core model: checks operands at start, answers a few cycles later.
    initial begin
        logic [95:0] e;
        logic [31:0] res;
        core_finished = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start && !rst) begin
                if (exp_core_q.size() == 0) begin
                    fail("core_start_unexpected");
                end else begin
                    e = exp_core_q.pop_front();
                    check("core_n", {32'd0, core_n}, {32'd0, e[95:64]});
                    check("core_d", {32'd0, core_d}, {32'd0, e[63:32]});
                    check("core_a", {32'd0, core_a}, {32'd0, e[31:0]});
                end
                res = modexp(core_a, core_d, core_n);
                if (early_fin) begin
                    core_result = 32'hDEAD_BEEF;
                    core_finished = 1'b1;
                    @(negedge clk);
                    core_finished = 1'b0;
                end
                repeat (3) @(negedge clk);
                core_result = res;
                core_finished = 1'b1;
                @(negedge clk);
                core_finished = 1'b0;
            end
        end
    end

    // TX monitor: every byte the DUT writes is matched against the scoreboard.
    initial begin
        logic [31:0] obs;
        forever begin
            @(posedge clk);
            #1;
            while (obs_tx_q.size() > 0) begin
                obs = obs_tx_q.pop_front();
                if (exp_tx_q.size() == 0) begin
                    $display("FAIL tx_unexpected: got %0h expected none", obs);
                    n_cmp++;
                    n_err++;
                end else begin
                    check("tx_byte", {32'd0, obs}, {32'd0, exp_tx_q.pop_front()});
                end
            end
        end
    end

    // Bus-hold monitor: a stalled access must present identical signals on the next cycle.
    initial begin
        logic [38:0] prev;
        bit prev_req;
        prev = '0;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && avm_waitrequest && prev_req)
                check("hold_stable", {25'd0, avm_address, avm_read, avm_write, avm_writedata}, {25'd0, prev});
            if (avm_read && avm_write) fail("read_and_write");
            prev = {avm_address, avm_read, avm_write, avm_writedata};
            prev_req = avm_read || avm_write;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) rx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic expect_block(input logic [31:0] n, input logic [31:0] d, input logic [31:0] a,
                                input logic [23:0] tx);
        exp_core_q.push_back({n, d, a});
        for (int i = 2; i >= 0; i--) exp_tx_q.push_back({24'd0, tx[8*i +: 8]});
    endtask

    task automatic wait_blocks(input int target);
        int t;
        t = 0;
        while (o_blocks_done != 16'(target) && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("blocks_done", {48'd0, o_blocks_done}, 64'(target));
    endtask

    initial begin
        int st0, tx0, t;
        rst = 1'b1;
        i_rekey = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", {63'd0, avm_read}, 64'd1);
        check("rst_addr", {59'd0, avm_address}, 64'd8);
        check("rst_write", {63'd0, avm_write}, 64'd0);
        check("rst_wdata", {32'd0, avm_writedata}, 64'd0);
        check("rst_start", {63'd0, core_start}, 64'd0);
        check("rst_blocks", {48'd0, o_blocks_done}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // T1: basic block, 2^7 mod 187 = 128
        expect_block(32'hBB, 32'h7, 32'h2, 24'h000080);
        push_word(32'hBB); push_word(32'h7); push_word(32'h2);
        wait_blocks(1);
        @(negedge clk);
        check("t1_idle_busy", {63'd0, o_busy}, 64'd0);
        check("t1_tx_drained", 64'(exp_tx_q.size()), 64'd0);

        // T2: 5-cycle waitrequest on every access, keys reused
        wait_cycles = 5;
        expect_block(32'hBB, 32'h7, 32'h2, 24'h000080);
        push_word(32'h2);
        wait_blocks(2);
        wait_cycles = 0;

        // T3: two blocks on one key: 3^7 mod 187 = 130, 5^7 mod 187 = 146
        expect_block(32'hBB, 32'h7, 32'h3, 24'h000082);
        expect_block(32'hBB, 32'h7, 32'h5, 24'h000092);
        push_word(32'h3); push_word(32'h5);
        wait_blocks(4);

        // T4: rekey during calculation; next words are N=247, D=5, A=3 -> 243
        expect_block(32'hBB, 32'h7, 32'h2, 24'h000080);
        push_word(32'h2);
        t = 0;
        while (!core_start && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!core_start) fail("t4_start_timeout");
        i_rekey = 1'b1;
        @(negedge clk);
        i_rekey = 1'b0;
        expect_block(32'hF7, 32'h5, 32'h3, 24'h0000F3);
        push_word(32'hF7); push_word(32'h5); push_word(32'h3);
        wait_blocks(6);

        // T5: RX not ready for a while; bogus finished on the start cycle; 2^5 mod 247 = 32
        rx_gate = 1'b0;
        early_fin = 1'b1;
        st0 = status_reads;
        expect_block(32'hF7, 32'h5, 32'h2, 24'h000020);
        push_word(32'h2);
        t = 0;
        while (status_reads - st0 < 10 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("t5_polls_seen", 64'(status_reads - st0 >= 10), 64'd1);
        check("t5_no_rx_read", 64'(bad_rx), 64'd0);
        rx_gate = 1'b1;
        wait_blocks(7);
        early_fin = 1'b0;

        // T6: reset after two of three TX bytes
        exp_core_q.push_back({32'hF7, 32'h5, 32'h3});
        exp_tx_q.push_back(32'h00);
        exp_tx_q.push_back(32'h00);
        tx0 = tx_total;
        push_word(32'h3);
        t = 0;
        while (tx_total < tx0 + 2 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (tx_total < tx0 + 2) fail("t6_tx_timeout");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_read", {63'd0, avm_read}, 64'd1);
        check("t6_rst_addr", {59'd0, avm_address}, 64'd8);
        check("t6_rst_write", {63'd0, avm_write}, 64'd0);
        check("t6_rst_blocks", {48'd0, o_blocks_done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_no_more_tx", 64'(tx_total), 64'(tx0 + 2));
        check("t6_busy_keyload", {63'd0, o_busy}, 64'd1);
        expect_block(32'hBB, 32'h7, 32'h2, 24'h000080);
        push_word(32'hBB); push_word(32'h7); push_word(32'h2);
        wait_blocks(1);

        repeat (3) @(negedge clk);
        check("end_tx_queue", 64'(exp_tx_q.size()), 64'd0);
        check("end_core_queue", 64'(exp_core_q.size()), 64'd0);
        check("end_bad_rx", 64'(bad_rx), 64'd0);
        check("end_bad_access", 64'(bad_acc), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
